// File: rtl/fd_queue_pkg.sv
// fd_queue_pkg: shared widths and the packed entry layout for the fetch/decode
// queue. One entry is {packet, is_BR_T_NT, BP_target, BP_alias}, stored as one
// word. The packet occupies the MSBs.
package fd_queue_pkg;

  localparam int PKT_W      = 128;
  localparam int BPT_W      = 32;
  localparam int BPA_W      = 6;
  localparam int FD_ENTRY_W = PKT_W + 1 + BPT_W + BPA_W;  // 167

  typedef struct packed {
    logic [PKT_W-1:0] packet;
    logic             is_br_t_nt;
    logic [BPT_W-1:0] bp_target;
    logic [BPA_W-1:0] bp_alias;
  } fd_entry_t;

endpackage

// File: rtl/fd_queue_mem.sv
// fd_queue_mem: DEPTH x fd_entry_t register array for the fetch/decode queue.
// Ports:
//   clk_i      clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  entry to store
//   rd_addr_i  read address
//   rd_data_o  entry at rd_addr_i (asynchronous read)
// The storage has no reset. Its contents only matter once the queue has
// written them.
module fd_queue_mem
  import fd_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  fd_entry_t     wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output fd_entry_t     rd_data_o
);

  fd_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fd_queue.sv
// fd_queue: in-order decoupling queue between fetch and decode.
// Ports:
//   clk, reset (sync, active-high)  clock and reset
//   resteer                         writeback resteer; flushes the queue
//   f_packet, f_packet_valid,
//   f_is_BR_T_NT, f_BP_target,
//   f_BP_alias                      incoming fetch packet and sideband
//   stall                           registered hold request to fetch
//   d_valid, d_ready                head handshake with decode
//   d_packet, d_is_BR_T_NT,
//   d_BP_target, d_BP_alias         head entry
//   overflow                        sticky: a packet was dropped because the
//                                   queue was full
//   count                           current occupancy
// stall rises when occupancy reaches DEPTH-SKID. Fetch has a one-cycle
// response latency, so the SKID reserved slots absorb packets already in
// flight when stall rises.
module fd_queue
  import fd_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SKID  = 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               resteer,
  input  logic [PKT_W-1:0]   f_packet,
  input  logic               f_packet_valid,
  input  logic               f_is_BR_T_NT,
  input  logic [BPT_W-1:0]   f_BP_target,
  input  logic [BPA_W-1:0]   f_BP_alias,
  output logic               stall,
  output logic               d_valid,
  input  logic               d_ready,
  output logic [PKT_W-1:0]   d_packet,
  output logic               d_is_BR_T_NT,
  output logic [BPT_W-1:0]   d_BP_target,
  output logic [BPA_W-1:0]   d_BP_alias,
  output logic               overflow,
  output logic [CNT_W-1:0]   count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(DEPTH - SKID);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stall_q, stall_d;
  logic             overflow_q, overflow_d;

  logic      full, push, pop, mem_we;
  fd_entry_t wr_entry, rd_entry;

  assign full    = (count_q == FULL_CNT);
  assign d_valid = (count_q != '0);
  assign pop     = d_valid & d_ready;
  // When the queue is full, a simultaneous pop frees the slot this edge.
  assign push    = f_packet_valid & (!full | pop);

  assign wr_entry = '{packet:     f_packet,
                      is_br_t_nt: f_is_BR_T_NT,
                      bp_target:  f_BP_target,
                      bp_alias:   f_BP_alias};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    stall_d    = stall_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    if (resteer) begin
      // A flush discards this cycle's push and pop but keeps overflow.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      stall_d  = 1'b0;
    end else begin
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
      if (f_packet_valid && full && !pop) begin
        overflow_d = 1'b1;
      end
      stall_d = (count_d >= STALL_TH);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  fd_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i     (clk),
    .wr_en_i   (mem_we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_entry)
  );

  assign d_packet     = rd_entry.packet;
  assign d_is_BR_T_NT = rd_entry.is_br_t_nt;
  assign d_BP_target  = rd_entry.bp_target;
  assign d_BP_alias   = rd_entry.bp_alias;
  assign stall        = stall_q;
  assign overflow     = overflow_q;
  assign count        = count_q;

endmodule
